branch_resolver: RTL and testbench

Execute-side companion to the branch predictor. Holds every in-flight predicted branch in program order, checks each against the outcome resolved by execute, and drives the predictor's training interface plus a redirect/flush to fetch on a mispredict. Sits between fetch (which enqueues predictions) and execute (which resolves branches in order).

---
 rtl/common.sv | 18 +
 rtl/branch_queue.sv | 52 +++++
 rtl/branch_resolver.sv | 104 ++++++++++
 tb/tb_branch_resolver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types and constants for the branch resolution path.
package common;

  typedef logic [63:0] u64;

  typedef struct packed {
    u64   pc;
    logic pred_taken;
    u64   pred_target;
  } branch_entry_t;

  localparam int unsigned BR_QUEUE_DEPTH = 8;

  // Resolver FSM encoding
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

endpackage

// File: rtl/branch_queue.sv
// Circular FIFO of in-flight predicted branches with synchronous clear.
// Callers must only push when not full and only pop when not empty.
module branch_queue
  import common::*;
#(
  parameter int unsigned DEPTH = BR_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  branch_entry_t      push_data,
  input  logic               pop,
  output branch_entry_t      head_data,
  output logic [OCC_W-1:0]   occupancy,
  output logic               full,
  output logic               empty
);

  branch_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;

  // Entry storage; a clear cycle drops any concurrent write
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[tail_q] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push) tail_q <= tail_q + PTR_W'(1);
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = mem[head_q];
  assign occupancy = occ_q;
  assign full      = (occ_q == OCC_W'(DEPTH));
  assign empty     = (occ_q == '0);

endmodule

// File: rtl/branch_resolver.sv
// Checks in-order resolved branches against their predictions, trains the
// predictor and redirects fetch on a mispredict.
module branch_resolver
  import common::*;
#(
  parameter int unsigned DEPTH = BR_QUEUE_DEPTH,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [63:0]              push_pc,
  input  logic                     push_pred_taken,
  input  logic [63:0]              push_pred_target,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic [63:0]              resolve_target,
  output logic                     fb_valid,
  output logic [63:0]              fb_pc,
  output logic                     fb_taken,
  output logic                     redirect_valid,
  output logic [63:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic                     err_underflow
);

  logic [0:0]    state_q, state_d;
  branch_entry_t head;
  branch_entry_t push_entry;
  logic          full, empty;
  logic          in_run;
  logic          push_fire, resolve_fire, underflow;
  logic          mispredict;
  logic [63:0]   fix_pc;

  assign in_run       = (state_q == ST_RUN);
  assign push_ready   = !full && in_run;
  assign push_fire    = push_valid && push_ready;
  assign resolve_fire = resolve_valid && in_run && !empty;
  assign underflow    = resolve_valid && in_run && empty;
  assign push_entry   = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};

  // Direction or taken-target disagreement against the oldest entry
  always_comb begin
    mispredict = (head.pred_taken != resolve_taken) ||
                 (head.pred_taken && resolve_taken && (head.pred_target != resolve_target));
    fix_pc     = resolve_taken ? resolve_target : head.pc + 64'd4;
  end

  // Mispredict flushes the queue; a same-cycle push is wrong-path and dropped
  branch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (resolve_fire && mispredict),
    .push      (push_fire),
    .push_data (push_entry),
    .pop       (resolve_fire),
    .head_data (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  // REDIRECT always lasts a single cycle
  always_comb begin
    state_d = ST_RUN;
    if (in_run && resolve_fire && mispredict) state_d = ST_REDIRECT;
  end

  // FSM, feedback/redirect registers, statistics and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      fb_valid       <= 1'b0;
      fb_pc          <= '0;
      fb_taken       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
      err_underflow  <= 1'b0;
    end else begin
      state_q        <= state_d;
      fb_valid       <= resolve_fire;
      redirect_valid <= resolve_fire && mispredict;
      if (resolve_fire) begin
        fb_pc      <= head.pc;
        fb_taken   <= resolve_taken;
        branch_cnt <= branch_cnt + CNT_W'(1);
        if (mispredict) begin
          redirect_pc <= fix_pc;
          mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
      end
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_resolver;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push_valid = 1'b0;
  logic             push_ready;
  logic [63:0]      push_pc = '0;
  logic             push_pred_taken = 1'b0;
  logic [63:0]      push_pred_target = '0;
  logic             resolve_valid = 1'b0;
  logic             resolve_taken = 1'b0;
  logic [63:0]      resolve_target = '0;
  logic             fb_valid;
  logic [63:0]      fb_pc;
  logic             fb_taken;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic             err_underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  branch_resolver #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .fb_valid         (fb_valid),
    .fb_pc            (fb_pc),
    .fb_taken         (fb_taken),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .occupancy        (occupancy),
    .branch_cnt       (branch_cnt),
    .mispred_cnt      (mispred_cnt),
    .err_underflow    (err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [63:0] pc;
    logic        pt;
    logic [63:0] tg;
  } ment_t;

  ment_t            mq[$];
  bit               m_redir;
  logic             m_fb_valid, m_fb_taken, m_rd_valid;
  logic [63:0]      m_fb_pc, m_rd_pc;
  logic [CNT_W-1:0] m_bcnt, m_mcnt;
  logic             m_err;

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    bit    ready, push_ok, res_ok, mis;
    ment_t e;
    if (rst) begin
      mq.delete();
      m_redir = 0; m_fb_valid = 0; m_fb_taken = 0; m_rd_valid = 0;
      m_fb_pc = '0; m_rd_pc = '0; m_bcnt = '0; m_mcnt = '0; m_err = 0;
      return;
    end
    ready   = (mq.size() < DEPTH) && !m_redir;
    push_ok = push_valid && ready;
    res_ok  = resolve_valid && !m_redir && (mq.size() > 0);
    if (resolve_valid && !m_redir && mq.size() == 0) m_err = 1;
    mis = 0;
    m_fb_valid = res_ok;
    m_rd_valid = 0;
    if (res_ok) begin
      e = mq.pop_front();
      mis = (e.pt != resolve_taken) || (e.pt && resolve_taken && e.tg != resolve_target);
      m_fb_pc = e.pc;
      m_fb_taken = resolve_taken;
      m_bcnt = m_bcnt + 1;
      if (mis) begin
        m_rd_valid = 1;
        m_rd_pc = resolve_taken ? resolve_target : e.pc + 64'd4;
        m_mcnt = m_mcnt + 1;
        mq.delete();
      end
    end
    if (push_ok && !mis) mq.push_back('{pc: push_pc, pt: push_pred_taken, tg: push_pred_target});
    m_redir = mis;
  endtask

  // Drive one cycle of stimulus, clock it, sample 1 time unit after the edge
  task automatic cycle(input logic pv, input logic [63:0] pc, input logic pt,
                       input logic [63:0] ptg, input logic rv, input logic rt,
                       input logic [63:0] rtg);
    push_valid = pv; push_pc = pc; push_pred_taken = pt; push_pred_target = ptg;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
    @(posedge clk);
    model_step();
    #1;
    push_valid = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    total_cnt++; if (push_ready !== 1'b1) $display("FAIL rst_push_ready got %0h exp 1", push_ready); else pass_cnt++;
    total_cnt++; if (occupancy !== '0) $display("FAIL rst_occupancy got %0d exp 0", occupancy); else pass_cnt++;
    total_cnt++; if ({fb_valid, fb_taken, redirect_valid, err_underflow} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {fb_valid, fb_taken, redirect_valid, err_underflow}); else pass_cnt++;
    total_cnt++; if ({fb_pc, redirect_pc} !== 128'd0) $display("FAIL rst_pcs got %h %h exp 0 0", fb_pc, redirect_pc); else pass_cnt++;
    total_cnt++; if ({branch_cnt, mispred_cnt} !== 64'd0) $display("FAIL rst_counters got %0d %0d exp 0 0", branch_cnt, mispred_cnt); else pass_cnt++;
  endtask

  task automatic test_correct_taken();
    cycle(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0, 1'b0, '0);
    total_cnt++; if (occupancy !== OCC_W'(1)) $display("FAIL ct_occ got %0d exp 1", occupancy); else pass_cnt++;
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 64'h2000);
    total_cnt++; if ({fb_valid, fb_taken, redirect_valid} !== 3'b110) $display("FAIL ct_flags got %b exp 110", {fb_valid, fb_taken, redirect_valid}); else pass_cnt++;
    total_cnt++; if (fb_pc !== 64'h1000) $display("FAIL ct_fb_pc got %h exp 1000", fb_pc); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 32'd1) $display("FAIL ct_branch_cnt got %0d exp 1", branch_cnt); else pass_cnt++;
    idle();
    total_cnt++; if (fb_valid !== 1'b0) $display("FAIL ct_fb_pulse got %0h exp 0", fb_valid); else pass_cnt++;
  endtask

  task automatic test_mispredict();
    logic [CNT_W-1:0] m0;
    m0 = mispred_cnt;
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h1000 + 64'(i * 16), 1'b0, '0, 1'b0, 1'b0, '0);
    total_cnt++; if (occupancy !== OCC_W'(3)) $display("FAIL mp_occ_before got %0d exp 3", occupancy); else pass_cnt++;
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 64'h3000);
    total_cnt++; if (redirect_valid !== 1'b1) $display("FAIL mp_redirect_valid got %0h exp 1", redirect_valid); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 64'h3000) $display("FAIL mp_redirect_pc got %h exp 3000", redirect_pc); else pass_cnt++;
    total_cnt++; if (occupancy !== '0) $display("FAIL mp_occ_after got %0d exp 0", occupancy); else pass_cnt++;
    total_cnt++; if (mispred_cnt !== m0 + 1) $display("FAIL mp_mispred_cnt got %0d exp %0d", mispred_cnt, m0 + 1); else pass_cnt++;
    total_cnt++; if (push_ready !== 1'b0) $display("FAIL mp_push_ready_low got %0h exp 0", push_ready); else pass_cnt++;
    idle();
    total_cnt++; if ({push_ready, redirect_valid} !== 2'b10) $display("FAIL mp_recover got %b exp 10", {push_ready, redirect_valid}); else pass_cnt++;
  endtask

  task automatic test_not_taken_redirect();
    cycle(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 64'h2000);
    total_cnt++; if ({redirect_valid, fb_taken} !== 2'b10) $display("FAIL nt_flags got %b exp 10", {redirect_valid, fb_taken}); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 64'h1004) $display("FAIL nt_redirect_pc got %h exp 1004", redirect_pc); else pass_cnt++;
    idle();
  endtask

  task automatic test_full_and_wrap();
    logic [63:0] exp_pc [DEPTH];
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'(i + 1) << 8, 1'b0, '0, 1'b0, 1'b0, '0);
    total_cnt++; if (push_ready !== 1'b0) $display("FAIL full_push_ready got %0h exp 0", push_ready); else pass_cnt++;
    total_cnt++; if (occupancy !== OCC_W'(DEPTH)) $display("FAIL full_occ got %0d exp %0d", occupancy, DEPTH); else pass_cnt++;
    // Push while full alongside a correct resolve: push must be rejected
    cycle(1'b1, 64'h900, 1'b0, '0, 1'b1, 1'b0, '0);
    total_cnt++; if (occupancy !== OCC_W'(DEPTH - 1)) $display("FAIL full_nobypass_occ got %0d exp %0d", occupancy, DEPTH - 1); else pass_cnt++;
    total_cnt++; if (fb_pc !== 64'h100) $display("FAIL full_first_pop got %h exp 100", fb_pc); else pass_cnt++;
    cycle(1'b1, 64'hA00, 1'b0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH - 1; i++) exp_pc[i] = 64'(i + 2) << 8;
    exp_pc[DEPTH - 1] = 64'hA00;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
      total_cnt++; if ({fb_valid, fb_pc} !== {1'b1, exp_pc[i]}) $display("FAIL drain_%0d got %0h/%h exp 1/%h", i, fb_valid, fb_pc, exp_pc[i]); else pass_cnt++;
    end
    total_cnt++; if ({push_ready, occupancy} !== {1'b1, OCC_W'(0)}) $display("FAIL drain_empty got %0h/%0d exp 1/0", push_ready, occupancy); else pass_cnt++;
  endtask

  task automatic test_underflow();
    logic [CNT_W-1:0] b0;
    b0 = branch_cnt;
    cycle(1'b1, 64'h6000, 1'b0, '0, 1'b1, 1'b0, '0);
    total_cnt++; if ({err_underflow, fb_valid} !== 2'b10) $display("FAIL uf_flags got %b exp 10", {err_underflow, fb_valid}); else pass_cnt++;
    total_cnt++; if (branch_cnt !== b0) $display("FAIL uf_branch_cnt got %0d exp %0d", branch_cnt, b0); else pass_cnt++;
    total_cnt++; if (occupancy !== OCC_W'(1)) $display("FAIL uf_push_kept got %0d exp 1", occupancy); else pass_cnt++;
    idle();
    total_cnt++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky got %0h exp 1", err_underflow); else pass_cnt++;
    rst = 1'b1;
    idle();
    rst = 1'b0;
    total_cnt++; if ({err_underflow, fb_valid, redirect_valid, occupancy, branch_cnt, mispred_cnt, fb_pc, redirect_pc} !== '0) $display("FAIL uf_reset got err=%0h occ=%0d bc=%0d mc=%0d fbpc=%h rdpc=%h exp all 0", err_underflow, occupancy, branch_cnt, mispred_cnt, fb_pc, redirect_pc); else pass_cnt++;
    total_cnt++; if (push_ready !== 1'b1) $display("FAIL uf_reset_ready got %0h exp 1", push_ready); else pass_cnt++;
  endtask

  task automatic test_wrong_path_push();
    logic [CNT_W-1:0] b0;
    cycle(1'b1, 64'h4000, 1'b0, '0, 1'b0, 1'b0, '0);
    cycle(1'b1, 64'h5000, 1'b0, '0, 1'b1, 1'b1, 64'h4444);
    total_cnt++; if ({redirect_valid, occupancy} !== {1'b1, OCC_W'(0)}) $display("FAIL wp_discard got %0h/%0d exp 1/0", redirect_valid, occupancy); else pass_cnt++;
    b0 = branch_cnt;
    // Resolve during the REDIRECT cycle must be ignored entirely
    cycle(1'b1, 64'h7000, 1'b0, '0, 1'b1, 1'b0, '0);
    total_cnt++; if ({fb_valid, err_underflow, occupancy} !== {2'b00, OCC_W'(0)}) $display("FAIL wp_ignored got %0h/%0h/%0d exp 0/0/0", fb_valid, err_underflow, occupancy); else pass_cnt++;
    total_cnt++; if (branch_cnt !== b0) $display("FAIL wp_branch_cnt got %0d exp %0d", branch_cnt, b0); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [63:0] pc, ptg, rtg;
    logic        pv, pt, rv, rt;
    logic [255:0] got, exp;
    for (int n = 0; n < 500; n++) begin
      pv  = ($urandom_range(0, 9) < 6);
      pc  = 64'($urandom_range(0, 255)) << 4;
      pt  = $urandom_range(0, 1) == 1;
      ptg = 64'($urandom_range(0, 15)) << 8;
      rv  = ($urandom_range(0, 9) < 5);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt  = mq[0].pt;
        rtg = ($urandom_range(0, 7) == 0) ? {32'($urandom), 32'($urandom)} : mq[0].tg;
      end else begin
        rt  = $urandom_range(0, 1) == 1;
        rtg = 64'($urandom_range(0, 15)) << 8;
      end
      cycle(pv, pc, pt, ptg, rv, rt, rtg);
      got = {fb_valid, fb_pc, fb_taken, redirect_valid, redirect_pc, occupancy, push_ready,
             branch_cnt, mispred_cnt, err_underflow};
      exp = {m_fb_valid, m_fb_pc, m_fb_taken, m_rd_valid, m_rd_pc, OCC_W'(mq.size()),
             (mq.size() < DEPTH) && !m_redir, m_bcnt, m_mcnt, m_err};
      total_cnt++; if (got !== exp) $display("FAIL rand_cycle_%0d got %h exp %h", n, got, exp); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_mispredict();
    test_not_taken_redirect();
    test_full_and_wrap();
    test_underflow();
    test_wrong_path_push();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
